// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
// Bundle carrying the raster timing outputs of vga_timing_gen to the
// framebuffer / pixel pipeline. Every signal is registered at the source and
// all of them are aligned to the same pixel.
//   o_hs, o_vs   : horizontal / vertical sync (polarity set by the generator)
//   o_de         : display enable, high inside the active area
//   o_sol, o_sof : start-of-line / start-of-frame one-pixel strobes
//   o_x, o_y     : raw beam coordinates
//   o_px, o_py   : integer-scaled framebuffer coordinates
// Modports: master (generator drives), slave (consumer reads).
// -----------------------------------------------------------------------------
interface vga_timing_if #(
    parameter int CW = 11
);
    logic          o_hs;
    logic          o_vs;
    logic          o_de;
    logic          o_sol;
    logic          o_sof;
    logic [CW-1:0] o_x;
    logic [CW-1:0] o_y;
    logic [CW-1:0] o_px;
    logic [CW-1:0] o_py;

    modport master (
        output o_hs, o_vs, o_de, o_sol, o_sof, o_x, o_y, o_px, o_py
    );

    modport slave (
        input  o_hs, o_vs, o_de, o_sol, o_sof, o_x, o_y, o_px, o_py
    );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator. Produces sync pulses with selectable
// polarity, display enable, beam coordinates, start-of-line/frame strobes and
// integer-scaled framebuffer coordinates. Line and frame order is
// active, front porch, sync, back porch.
//
// Ports:
//   i_clk  : pixel clock
//   i_rst  : synchronous active-high reset (wins over i_en)
//   i_en   : clock enable; low freezes every register including strobes
//   o_vid  : vga_timing_if master modport with all registered outputs
//
// Build option:
//   VGA_TIMING_SCALE_EN defined   : replication sub-counters produce
//                                   o_px = x / H_SCALE, o_py = y / V_SCALE
//                                   (divide-free), holding through blanking.
//   VGA_TIMING_SCALE_EN undefined : o_px/o_py mirror o_x/o_y.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CW       = 11,
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int H_SCALE  = 2,
    parameter int V_SCALE  = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    vga_timing_if.master o_vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (1 << CW)) begin : g_err_htotal
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : g_err_vtotal
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (H_SCALE < 1 || V_SCALE < 1) begin : g_err_scale
        $error("vga_timing_gen: scale factors must be at least 1");
    end

    // Region bounds are compared one bit wider than the counters so that a
    // bound equal to 2^CW is still representable.
    localparam logic [CW:0]   HA_END = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   VA_END = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0]   VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] X_MAX  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_MAX  = CW'(V_TOTAL - 1);
    localparam logic          HSP    = (HS_POL != 0);
    localparam logic          VSP    = (VS_POL != 0);

    logic [CW-1:0] r_x, r_y;
    logic          r_hs, r_vs, r_de, r_sol, r_sof;

    logic          w_x_wrap, w_y_wrap;
    logic [CW-1:0] w_x_nxt, w_y_nxt;
    logic [CW:0]   w_x_ext, w_y_ext;
    logic          w_hact, w_vact, w_hsync, w_vsync;

    // Every output is registered from the *next* beam position, so all of
    // them describe the same pixel as o_x/o_y in the same cycle.
    assign w_x_wrap = (r_x == X_MAX);
    assign w_y_wrap = (r_y == Y_MAX);
    assign w_x_nxt  = w_x_wrap ? '0 : r_x + 1'b1;
    assign w_y_nxt  = w_x_wrap ? (w_y_wrap ? '0 : r_y + 1'b1) : r_y;
    assign w_x_ext  = {1'b0, w_x_nxt};
    assign w_y_ext  = {1'b0, w_y_nxt};
    assign w_hact   = (w_x_ext < HA_END);
    assign w_vact   = (w_y_ext < VA_END);
    assign w_hsync  = (w_x_ext >= HS_BEG) && (w_x_ext < HS_END);
    assign w_vsync  = (w_y_ext >= VS_BEG) && (w_y_ext < VS_END);

    // Reset parks the beam on the last pixel of the frame so the first
    // enabled edge lands on (0,0) with both strobes set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x   <= X_MAX;
            r_y   <= Y_MAX;
            r_de  <= 1'b0;
            r_sol <= 1'b0;
            r_sof <= 1'b0;
            r_hs  <= ~HSP;
            r_vs  <= ~VSP;
        end else if (i_en) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_de  <= w_hact && w_vact;
            r_sol <= w_x_wrap;
            r_sof <= w_x_wrap && w_y_wrap;
            r_hs  <= w_hsync ? HSP : ~HSP;
            r_vs  <= w_vsync ? VSP : ~VSP;
        end
    end

`ifdef VGA_TIMING_SCALE_EN
    localparam logic [CW-1:0] H_SUB_MAX = CW'(H_SCALE - 1);
    localparam logic [CW-1:0] V_SUB_MAX = CW'(V_SCALE - 1);

    logic [CW-1:0] r_hsub, r_vsub, r_px, r_py;

    // Sub-counters count pixel/line repeats; the scaled coordinate steps when
    // a sub-counter completes a run of SCALE. They only advance inside the
    // active span, which makes o_px/o_py hold through blanking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hsub <= '0;
            r_vsub <= '0;
            r_px   <= '0;
            r_py   <= '0;
        end else if (i_en) begin
            if (w_x_wrap) begin
                r_hsub <= '0;
                r_px   <= '0;
            end else if (w_hact) begin
                if (r_hsub == H_SUB_MAX) begin
                    r_hsub <= '0;
                    r_px   <= r_px + 1'b1;
                end else begin
                    r_hsub <= r_hsub + 1'b1;
                end
            end

            // Vertical replication advances once per line, at the wrap.
            if (w_x_wrap) begin
                if (w_y_wrap) begin
                    r_vsub <= '0;
                    r_py   <= '0;
                end else if (w_vact) begin
                    if (r_vsub == V_SUB_MAX) begin
                        r_vsub <= '0;
                        r_py   <= r_py + 1'b1;
                    end else begin
                        r_vsub <= r_vsub + 1'b1;
                    end
                end
            end
        end
    end

    assign o_vid.o_px = r_px;
    assign o_vid.o_py = r_py;
`else
    assign o_vid.o_px = r_x;
    assign o_vid.o_py = r_y;
`endif

    assign o_vid.o_x   = r_x;
    assign o_vid.o_y   = r_y;
    assign o_vid.o_hs  = r_hs;
    assign o_vid.o_vs  = r_vs;
    assign o_vid.o_de  = r_de;
    assign o_vid.o_sol = r_sol;
    assign o_vid.o_sof = r_sof;

endmodule
